// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared state type and default limits for the run sequencer
package seq_pkg;

    // Run phases, in the order a normal run walks through them.
    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_RUN,
        S_DRAIN,
        S_DONE
    } seq_state_t;

    localparam logic [11:0] DEF_END_PC  = 12'hFFF;
    localparam int          DEF_MAX_CYC = 4000;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up-counter with synchronous clear that sticks at all-ones
//
// Ports:
//   clk    in   1  system clock
//   reset  in   1  synchronous active-high reset, forces count to 0
//   clear  in   1  synchronous clear, forces count to 0
//   inc    in   1  add one this cycle unless already saturated
//   count  out  W  current count
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/run_sequencer.sv
// rtl/run_sequencer.sv - sequences one program run of the 9-bit core (reset, run, drain, done)
//
// Ports:
//   clk        in   1   system clock
//   reset      in   1   synchronous active-high reset
//   req        in   1   host start request, level sampled every cycle
//   halt       in   1   decoder halt flag for the instruction at prog_ctr
//   prog_ctr   in   D   current core PC
//   core_rst   out  1   reset to PC / reg file / flags
//   run_en     out  1   PC advance and RegWrite/MemWrite qualifier
//   done       out  1   run complete, held until req falls
//   timeout    out  1   run was ended by the watchdog (meaningful while done=1)
//   cycle_cnt  out  CW  RUN cycles of the last/current run, saturating
module run_sequencer
    import seq_pkg::*;
#(
    parameter int           D       = 12,
    parameter int           CW      = 16,
    parameter int           RST_CYC = 2,
    parameter int           MAX_CYC = DEF_MAX_CYC,
    parameter logic [D-1:0] END_PC  = D'(DEF_END_PC)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          halt,
    input  logic [D-1:0]  prog_ctr,
    output logic          core_rst,
    output logic          run_en,
    output logic          done,
    output logic          timeout,
    output logic [CW-1:0] cycle_cnt
);

    localparam int HW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    seq_state_t    state;
    seq_state_t    next_state;
    logic [HW-1:0] hold_cnt;

    logic watchdog;
    logic end_cond;
    logic core_rst_d;
    logic run_en_d;
    logic done_d;
    logic timeout_d;

    assign watchdog = (MAX_CYC != 0) && (cycle_cnt == CW'(MAX_CYC - 1));
    assign end_cond = halt || (prog_ctr == END_PC) || watchdog;

    // State register plus registered outputs; outputs are decoded from
    // next_state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            core_rst <= 1'b1;
            run_en   <= 1'b0;
            done     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= next_state;
            core_rst <= core_rst_d;
            run_en   <= run_en_d;
            done     <= done_d;
            timeout  <= timeout_d;
        end
    end

    // HOLD length counter: reloaded whenever we are not holding, so each
    // entry into HOLD lasts exactly RST_CYC cycles.
    always_ff @(posedge clk) begin
        if (reset || (state != S_HOLD)) begin
            hold_cnt <= HW'(RST_CYC - 1);
        end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
        end
    end

    // Next-state logic. A low req outside IDLE/DONE aborts the run.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (req) next_state = S_HOLD;
            S_HOLD:  if (!req) next_state = S_IDLE;
                     else if (hold_cnt == '0) next_state = S_RUN;
            S_RUN:   if (!req) next_state = S_IDLE;
                     else if (end_cond) next_state = S_DRAIN;
            S_DRAIN: next_state = req ? S_DONE : S_IDLE;
            S_DONE:  if (!req) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Output decode. timeout is only updated when a run is accepted
    // (cleared) or when RUN ends normally; halt beats the watchdog.
    always_comb begin
        core_rst_d = (next_state == S_IDLE) || (next_state == S_HOLD);
        run_en_d   = (next_state == S_RUN);
        done_d     = (next_state == S_DONE);
        timeout_d  = timeout;
        if ((state == S_IDLE) && req) begin
            timeout_d = 1'b0;
        end else if ((state == S_RUN) && req && end_cond) begin
            timeout_d = watchdog && !halt;
        end
    end

    sat_counter #(.W(CW)) u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .clear ((state == S_IDLE) && req),
        .inc   (state == S_RUN),
        .count (cycle_cnt)
    );

endmodule

// File: tb/tb_run_sequencer.sv
// tb/tb_run_sequencer.sv - self-checking bench for run_sequencer (default watchdog and MAX_CYC=8 instances)
module tb_run_sequencer;

    localparam int RST = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        halt = 1'b0;
    logic [11:0] prog_ctr = 12'h000;

    logic        core_rst_a, run_en_a, done_a, timeout_a;
    logic [15:0] cycle_cnt_a;
    logic        core_rst_b, run_en_b, done_b, timeout_b;
    logic [15:0] cycle_cnt_b;

    int compared   = 0;
    int mismatched = 0;
    bit checking   = 1'b0;

    always #5 clk = ~clk;

    run_sequencer dut_a (
        .clk(clk), .reset(reset), .req(req), .halt(halt), .prog_ctr(prog_ctr),
        .core_rst(core_rst_a), .run_en(run_en_a), .done(done_a),
        .timeout(timeout_a), .cycle_cnt(cycle_cnt_a)
    );

    run_sequencer #(.MAX_CYC(8)) dut_b (
        .clk(clk), .reset(reset), .req(req), .halt(halt), .prog_ctr(prog_ctr),
        .core_rst(core_rst_b), .run_en(run_en_b), .done(done_b),
        .timeout(timeout_b), .cycle_cnt(cycle_cnt_b)
    );

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a run is "busy" from acceptance until drain ends;
    // age counts edges since acceptance, so the first RST edges are the
    // reset hold and later ones are execution until an end is seen.
    int max_c[2] = '{4000, 8};
    int busy[2]  = '{0, 0};
    int age[2]   = '{0, 0};
    int ended[2] = '{0, 0};
    int dn[2]    = '{0, 0};
    int to[2]    = '{0, 0};
    int cnt[2]   = '{0, 0};

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int running;
            int wd;
            running = busy[i] && (age[i] > RST) && !ended[i];
            wd = (max_c[i] != 0) && (cnt[i] == max_c[i] - 1);
            if (reset) begin
                busy[i] = 0; age[i] = 0; ended[i] = 0; dn[i] = 0; to[i] = 0; cnt[i] = 0;
            end else if (dn[i] != 0) begin
                if (!req) dn[i] = 0;
            end else if (busy[i] != 0) begin
                if (running && cnt[i] < 65535) cnt[i] = cnt[i] + 1;
                if (!req) begin
                    busy[i] = 0;
                end else if (ended[i] != 0) begin
                    busy[i] = 0; ended[i] = 0; dn[i] = 1;
                end else if (running && (halt || prog_ctr == 12'hFFF || wd)) begin
                    ended[i] = 1;
                    to[i] = wd && !halt;
                end
                age[i] = age[i] + 1;
            end else if (req) begin
                busy[i] = 1; age[i] = 1; cnt[i] = 0; to[i] = 0; ended[i] = 0;
            end
        end
    end

    task automatic compare_dut(input int i, input logic cr, input logic re,
                               input logic d, input logic t, input logic [15:0] cc);
        int exp_cr;
        int exp_re;
        exp_cr = ((!busy[i] && !dn[i]) || (busy[i] && age[i] <= RST)) ? 1 : 0;
        exp_re = (busy[i] && age[i] > RST && !ended[i]) ? 1 : 0;
        check($sformatf("core_rst[%0d]", i), int'(cr), exp_cr);
        check($sformatf("run_en[%0d]", i), int'(re), exp_re);
        check($sformatf("done[%0d]", i), int'(d), dn[i]);
        check($sformatf("timeout[%0d]", i), int'(t), to[i]);
        check($sformatf("cycle_cnt[%0d]", i), int'(cc), cnt[i]);
    endtask

    always @(negedge clk) begin
        if (checking) begin
            compare_dut(0, core_rst_a, run_en_a, done_a, timeout_a, cycle_cnt_a);
            compare_dut(1, core_rst_b, run_en_b, done_b, timeout_b, cycle_cnt_b);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        tick(3);
        checking = 1'b1;
        check("rst core_rst", int'(core_rst_a), 1);
        check("rst run_en", int'(run_en_a), 0);
        check("rst done", int'(done_a), 0);
        check("rst cycle_cnt", int'(cycle_cnt_a), 0);
        reset = 1'b0;
        tick(1);

        // Run 1: halt in RUN cycle 10; dut_b hits its watchdog at 8 first.
        req = 1'b1;
        tick(1);
        check("hold1 core_rst", int'(core_rst_a), 1);
        check("hold1 run_en", int'(run_en_a), 0);
        tick(1);
        check("hold2 core_rst", int'(core_rst_a), 1);
        tick(1);
        check("run start run_en", int'(run_en_a), 1);
        check("run start core_rst", int'(core_rst_a), 0);
        check("run start done", int'(done_a), 0);
        tick(9);
        halt = 1'b1;
        tick(1);
        halt = 1'b0;
        check("drain run_en", int'(run_en_a), 0);
        check("drain done", int'(done_a), 0);
        check("drain cycle_cnt", int'(cycle_cnt_a), 10);
        tick(1);
        check("halt done", int'(done_a), 1);
        check("halt timeout", int'(timeout_a), 0);
        check("halt cycle_cnt", int'(cycle_cnt_a), 10);
        check("wd done", int'(done_b), 1);
        check("wd timeout", int'(timeout_b), 1);
        check("wd cycle_cnt", int'(cycle_cnt_b), 8);

        // req held through DONE: no restart.
        tick(20);
        check("held done", int'(done_a), 1);
        check("held run_en", int'(run_en_a), 0);
        check("held cycle_cnt", int'(cycle_cnt_a), 10);

        // Run 2: halt coincides with dut_b watchdog (RUN cycle 8).
        req = 1'b0;
        tick(1);
        check("idle done", int'(done_a), 0);
        req = 1'b1;
        tick(3);
        tick(7);
        halt = 1'b1;
        tick(1);
        halt = 1'b0;
        tick(1);
        check("tie done", int'(done_b), 1);
        check("tie timeout", int'(timeout_b), 0);
        check("tie cycle_cnt", int'(cycle_cnt_b), 8);

        // Run 3: abort in RUN cycle 5, then restart and end on END_PC.
        req = 1'b0;
        tick(1);
        req = 1'b1;
        tick(3);
        tick(4);
        req = 1'b0;
        tick(1);
        check("abort done", int'(done_a), 0);
        check("abort core_rst", int'(core_rst_a), 1);
        check("abort cycle_cnt", int'(cycle_cnt_a), 5);
        req = 1'b1;
        tick(1);
        check("restart cycle_cnt", int'(cycle_cnt_a), 0);
        tick(2);
        tick(2);
        prog_ctr = 12'hFFF;
        tick(1);
        prog_ctr = 12'h000;
        tick(1);
        check("endpc done", int'(done_a), 1);
        check("endpc cycle_cnt", int'(cycle_cnt_a), 3);
        check("endpc timeout", int'(timeout_a), 0);

        // Run 4: reset mid-RUN.
        req = 1'b0;
        tick(1);
        req = 1'b1;
        tick(5);
        reset = 1'b1;
        req = 1'b0;
        tick(1);
        check("midrst core_rst", int'(core_rst_a), 1);
        check("midrst run_en", int'(run_en_a), 0);
        check("midrst cycle_cnt", int'(cycle_cnt_a), 0);
        reset = 1'b0;
        tick(2);

        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
